multdiv_sequencer: RTL and testbench

- Sequences the multi-cycle multiply/divide unit attached to the execute stage.
- Detects a mult/div instruction in execute and latches its operands and destination.
- Issues a one-cycle start pulse to the multdiv unit, then holds the pipeline stalled until the result is ready or a timeout expires.
- Delivers one writeback beat: the result to rd, or an error status code to r30 on exception.

---
 rtl/multdiv_sequencer_pkg.sv | 30 +++
 rtl/multdiv_sequencer_md_timeout_counter.sv | 37 +++
 rtl/multdiv_sequencer.sv | 163 ++++++++++++++++
 tb/tb_multdiv_sequencer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/multdiv_sequencer_pkg.sv
// Shared constants and types for the multiply/divide sequencer: decode values,
// exception status codes and the sequencer state encoding.
package multdiv_sequencer_pkg;

    localparam logic [4:0] ALU_OPCODE = 5'b00000;
    localparam logic [4:0] AOP_MUL    = 5'b00110;
    localparam logic [4:0] AOP_DIV    = 5'b00111;

    // Exception status codes written to the status register.
    localparam logic [31:0] STATUS_ADD_OVF  = 32'd1;
    localparam logic [31:0] STATUS_ADDI_OVF = 32'd2;
    localparam logic [31:0] STATUS_SUB_OVF  = 32'd3;
    localparam logic [31:0] STATUS_MUL_EXC  = 32'd4;
    localparam logic [31:0] STATUS_DIV_EXC  = 32'd5;

    localparam int STATUS_REG_NUM = 30;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_BUSY  = 2'b10,
        ST_DONE  = 2'b11
    } md_state_e;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } md_op_e;

endpackage

// File: rtl/multdiv_sequencer_md_timeout_counter.sv
// Wait counter for the multdiv handshake: synchronous clear, count enable,
// saturation at TIMEOUT_CYCLES and a flag on the last allowed wait cycle.
module multdiv_sequencer_md_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 40
) (
    input  logic clk,
    input  logic clr,
    input  logic clear,
    input  logic enable,
    output logic terminal
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] SAT_VALUE  = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST_VALUE = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != SAT_VALUE)) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign terminal = (count_q == LAST_VALUE);

endmodule

// File: rtl/multdiv_sequencer.sv
// Sequences one mult/div instruction from execute through the multi-cycle
// multdiv unit and emits a single writeback beat (result or status code).
module multdiv_sequencer
    import multdiv_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 40,
    parameter int STATUS_REG     = STATUS_REG_NUM,
    parameter int MULT_STATUS    = 4,
    parameter int DIV_STATUS     = 5
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        ex_valid,
    input  logic        is_mult,
    input  logic        is_div,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [4:0]  rd_in,
    input  logic        md_rdy,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    output logic        md_ctrl_mult,
    output logic        md_ctrl_div,
    output logic [31:0] md_operand_a,
    output logic [31:0] md_operand_b,
    output logic        stall,
    output logic        busy,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data
);
    md_state_e   state_q, state_d;
    md_op_e      op_q, op_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic        ctrl_mult_q, ctrl_mult_d;
    logic        ctrl_div_q, ctrl_div_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;

    logic start;
    logic cnt_clear, cnt_enable, cnt_terminal;
    logic finish, finish_exc;

    // Both decode flags at once is an illegal encoding and must not start anything.
    assign start = ex_valid & (is_mult ^ is_div);

    multdiv_sequencer_md_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .clr      (clr),
        .clear    (cnt_clear),
        .enable   (cnt_enable),
        .terminal (cnt_terminal)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rd_d        = rd_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        ctrl_mult_d = 1'b0;
        ctrl_div_d  = 1'b0;
        wb_valid_d  = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        cnt_clear   = 1'b0;
        cnt_enable  = 1'b0;
        finish      = 1'b0;
        finish_exc  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    opa_d       = operand_a;
                    opb_d       = operand_b;
                    rd_d        = rd_in;
                    op_d        = is_div ? OP_DIV : OP_MUL;
                    ctrl_mult_d = is_mult;
                    ctrl_div_d  = is_div;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_clear = 1'b1;
                state_d   = ST_BUSY;
            end
            ST_BUSY: begin
                cnt_enable = 1'b1;
                // A real result wins over the timeout in the same cycle.
                if (md_rdy) begin
                    finish     = 1'b1;
                    finish_exc = md_exception;
                end else if (cnt_terminal) begin
                    finish     = 1'b1;
                    finish_exc = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (finish) begin
            state_d    = ST_DONE;
            wb_valid_d = 1'b1;
            if (finish_exc) begin
                wb_rd_d   = 5'(STATUS_REG);
                wb_data_d = (op_q == OP_DIV) ? 32'(DIV_STATUS) : 32'(MULT_STATUS);
            end else begin
                wb_rd_d   = rd_q;
                wb_data_d = md_result;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_MUL;
            rd_q        <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            ctrl_mult_q <= 1'b0;
            ctrl_div_q  <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            ctrl_mult_q <= ctrl_mult_d;
            ctrl_div_q  <= ctrl_div_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
        end
    end

    // Gated by clr so a held start request cannot stall the pipe during reset.
    assign stall = ~clr & (((state_q == ST_IDLE) & start) |
                           (state_q == ST_ISSUE) | (state_q == ST_BUSY));
    assign busy  = (state_q != ST_IDLE);

    assign md_ctrl_mult = ctrl_mult_q;
    assign md_ctrl_div  = ctrl_div_q;
    assign md_operand_a = opa_q;
    assign md_operand_b = opb_q;
    assign wb_valid     = wb_valid_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed and randomized bench for multdiv_sequencer; expectations come from a
// per-operation cycle timeline derived from the sequencing rules.
module tb_multdiv_sequencer;
    localparam int T = 40;

    logic        clk = 1'b0;
    logic        clr;
    logic        ex_valid, is_mult, is_div;
    logic [31:0] operand_a, operand_b;
    logic [4:0]  rd_in;
    logic        md_rdy, md_exception;
    logic [31:0] md_result;
    logic        md_ctrl_mult, md_ctrl_div, stall, busy, wb_valid;
    logic [31:0] md_operand_a, md_operand_b, wb_data;
    logic [4:0]  wb_rd;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_a = '0;
    logic [31:0] last_b = '0;

    always #5 clk = ~clk;

    multdiv_sequencer #(
        .TIMEOUT_CYCLES(T), .STATUS_REG(30), .MULT_STATUS(4), .DIV_STATUS(5)
    ) dut (
        .clk(clk), .clr(clr), .ex_valid(ex_valid), .is_mult(is_mult), .is_div(is_div),
        .operand_a(operand_a), .operand_b(operand_b), .rd_in(rd_in),
        .md_rdy(md_rdy), .md_result(md_result), .md_exception(md_exception),
        .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
        .md_operand_a(md_operand_a), .md_operand_b(md_operand_b),
        .stall(stall), .busy(busy), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, stall, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ctrl_mult"}, md_ctrl_mult, 0);
        chk({tag, "_ctrl_div"}, md_ctrl_div, 0);
        chk({tag, "_wb_valid"}, wb_valid, 0);
        chk({tag, "_wb_rd"}, wb_rd, 0);
        chk({tag, "_wb_data"}, wb_data, 0);
        chk({tag, "_opa"}, md_operand_a, 0);
        chk({tag, "_opb"}, md_operand_b, 0);
    endtask

    // Called at a falling edge with the sequencer idle. Cycle 0 presents the
    // instruction, cycle 1 is the issue cycle, md_rdy arrives on wait cycle
    // 'delay' (delay > T means never), writeback lands right after.
    task automatic do_op(input bit div, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int delay, input bit exc,
                         input bit noise, input int abort_at);
        int done_c;
        bit exc_exp;
        logic [31:0] res, exp_data;
        logic [4:0] exp_rd;
        res      = div ? ((b == 0) ? 32'hDEAD_BEEF : a / b) : a * b;
        done_c   = 2 + ((delay >= 1 && delay <= T) ? delay : T);
        exc_exp  = (delay < 1 || delay > T) ? 1'b1 : exc;
        exp_rd   = exc_exp ? 5'd30 : rd;
        exp_data = exc_exp ? (div ? 32'd5 : 32'd4) : res;
        ex_valid = 1; is_mult = !div; is_div = div;
        operand_a = a; operand_b = b; rd_in = rd;
        for (int c = 0; c <= done_c; c++) begin
            md_rdy       = (c == 1 + delay) || (c == 1 && noise);
            md_result    = (c == 1) ? ~res : res;
            md_exception = (c == 1) ? !exc : exc;
            #1;
            if (c == abort_at) begin
                clr = 1;
                #1;
                chk_all_zero("abort");
                ex_valid = 0; is_mult = 0; is_div = 0; md_rdy = 0;
                @(negedge clk);
                chk_all_zero("abort_hold");
                clr = 0;
                last_a = '0; last_b = '0;
                @(negedge clk);
                return;
            end
            chk("stall", stall, 32'(c < done_c));
            chk("busy", busy, 32'(c > 0));
            chk("ctrl_mult", md_ctrl_mult, 32'(c == 1 && !div));
            chk("ctrl_div", md_ctrl_div, 32'(c == 1 && div));
            chk("wb_valid", wb_valid, 32'(c == done_c));
            if (c == 0) begin
                chk("opa_hold", md_operand_a, last_a);
                chk("opb_hold", md_operand_b, last_b);
            end else begin
                chk("opa", md_operand_a, a);
                chk("opb", md_operand_b, b);
            end
            if (c == done_c) begin
                chk("wb_rd", wb_rd, exp_rd);
                chk("wb_data", wb_data, exp_data);
                $display("op %s a=%0h b=%0h rd=%0d delay=%0d -> wb_rd=%0d wb_data=%0h (exp %0d/%0h)",
                         div ? "div" : "mul", a, b, rd, delay, wb_rd, wb_data, exp_rd, exp_data);
                ex_valid = 0; is_mult = 0; is_div = 0; md_rdy = 0;
            end
            @(negedge clk);
        end
        last_a = a; last_b = b;
    endtask

    task automatic ignored_cycle(input bit ev, input bit m, input bit d);
        ex_valid = ev; is_mult = m; is_div = d;
        operand_a = $urandom; operand_b = $urandom; rd_in = 5'($urandom);
        #1;
        chk("ign_stall", stall, 0);
        chk("ign_busy", busy, 0);
        chk("ign_ctrl_mult", md_ctrl_mult, 0);
        chk("ign_ctrl_div", md_ctrl_div, 0);
        chk("ign_wb_valid", wb_valid, 0);
        $display("ignored ex_valid=%0d is_mult=%0d is_div=%0d stall=%0d busy=%0d", ev, m, d, stall, busy);
        @(negedge clk);
        ex_valid = 0; is_mult = 0; is_div = 0;
    endtask

    initial begin
        bit div, exc;
        logic [31:0] a, b;
        clr = 1; ex_valid = 0; is_mult = 0; is_div = 0;
        operand_a = '0; operand_b = '0; rd_in = '0;
        md_rdy = 0; md_result = '0; md_exception = 0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        clr = 0;
        @(negedge clk);

        do_op(0, 32'd6, 32'd7, 5'd3, 16, 0, 0, -1);
        do_op(1, 32'd10, 32'd0, 5'd9, 8, 1, 0, -1);
        do_op(0, 32'd123, 32'd456, 5'd7, 1000, 0, 0, -1);
        do_op(1, 32'd77, 32'd7, 5'd8, 1000, 0, 0, -1);
        do_op(0, 32'd11, 32'd13, 5'd12, T, 0, 0, -1);
        do_op(0, 32'd3, 32'd5, 5'd4, 3, 0, 0, -1);
        do_op(1, 32'd100, 32'd9, 5'd5, 3, 0, 1, -1);
        do_op(0, 32'd2, 32'd2, 5'd1, 1, 0, 0, -1);

        ignored_cycle(0, 1, 0);
        ignored_cycle(0, 0, 1);
        ignored_cycle(1, 1, 1);
        ignored_cycle(1, 0, 0);

        do_op(0, 32'd21, 32'd2, 5'd6, 1000, 0, 0, 6);
        do_op(0, 32'd9, 32'd9, 5'd2, 5, 0, 0, -1);

        for (int i = 0; i < 20; i++) begin
            div = 1'($urandom);
            a = $urandom;
            b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom_range(1, 1000);
            exc = ($urandom_range(0, 3) == 0);
            if (div && b == 0) exc = 1;
            do_op(div, a, b, 5'($urandom), $urandom_range(1, T + 5), exc,
                  1'($urandom), -1);
            if ($urandom_range(0, 1) == 1) ignored_cycle(1, 1, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
